// File: rtl/decode_uop_queue.sv
// Decode-to-rename uop queue: compacts up to 2 uops per decode lane into a circular buffer
// and presents the oldest OUT_WIDTH entries to rename.
module decode_uop_queue #(
    parameter int unsigned FETCH_WIDTH = 4,
    parameter int unsigned OUT_WIDTH   = 4,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned UOP_W       = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid_i,
    input  logic [FETCH_WIDTH-1:0]             lane_active_i,
    input  logic [2*FETCH_WIDTH-1:0]           uop_valid_i,
    input  logic [2*FETCH_WIDTH*UOP_W-1:0]     uop_i,
    output logic                               in_ready_o,
    output logic [OUT_WIDTH-1:0]               out_valid_o,
    output logic [OUT_WIDTH*UOP_W-1:0]         out_uop_o,
    input  logic                               out_ready_i,
    input  logic                               flush_i,
    output logic [$clog2(DEPTH):0]             count_o
);

    localparam int unsigned SLOTS   = 2 * FETCH_WIDTH;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned OUT_CAP = (OUT_WIDTH < DEPTH) ? OUT_WIDTH : DEPTH;

    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - SLOTS);
    localparam logic [CNT_W-1:0] POP_MAX   = CNT_W'(OUT_CAP);

    logic [UOP_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push, pop;
    logic [SLOTS-1:0] slot_take;
    logic [CNT_W-1:0] slot_off [SLOTS];
    logic [CNT_W-1:0] push_n;
    logic [CNT_W-1:0] pop_n;

    always_comb begin
        in_ready_o = (count_q <= READY_MAX);
        push       = in_valid_i && in_ready_o && !flush_i;
        pop        = out_ready_i && !flush_i;

        // Prefix count over taken slots gives each uop its compacted offset from tail.
        push_n = '0;
        for (int s = 0; s < SLOTS; s++) begin
            slot_take[s] = uop_valid_i[s] & lane_active_i[s/2];
            slot_off[s]  = push_n;
            push_n       = push_n + CNT_W'(slot_take[s]);
        end

        pop_n = (count_q < POP_MAX) ? count_q : POP_MAX;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d  = tail_q + push_n[PTR_W-1:0];
                count_d = count_d + push_n;
            end
            if (pop) begin
                head_d  = head_q + pop_n[PTR_W-1:0];
                count_d = count_d - pop_n;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is not reset; out_valid_o masks anything stale.
    always_ff @(posedge clk) begin
        if (push && reset) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (slot_take[s]) begin
                    mem_q[tail_q + slot_off[s][PTR_W-1:0]] <= uop_i[s*UOP_W +: UOP_W];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < OUT_WIDTH; k++) begin
            out_valid_o[k]                 = (32'(count_q) > k);
            out_uop_o[k*UOP_W +: UOP_W]    = mem_q[head_q + PTR_W'(k)];
        end
    end

    assign count_o = count_q;

endmodule

// File: doc/decode_uop_queue.md
DECODE_UOP_QUEUE -- requirements
Module: decode_uop_queue

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 4: number of decode lanes; each lane yields up to 2 uops (part0, part1).
REQ-002 SHALL have parameter OUT_WIDTH, default 4: maximum uops delivered to rename per cycle.
REQ-003 SHALL have parameter DEPTH, default 16: queue entries; a power of 2 and >= 2*FETCH_WIDTH.
REQ-004 SHALL have parameter UOP_W, default 64: opaque uop payload width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid_i, input, 1 bit: a decoded bundle is offered.
REQ-008 SHALL have port lane_active_i, input, FETCH_WIDTH bits: dynamic-config lane enable.
REQ-009 SHALL have port uop_valid_i, input, 2*FETCH_WIDTH bits: bit 2g is lane g part0 and bit 2g+1 is lane g part1.
REQ-010 SHALL have port uop_i, input, 2*FETCH_WIDTH*UOP_W bits: payloads in the same slot order as uop_valid_i.
REQ-011 SHALL have port in_ready_o, output, 1 bit: the queue can accept a full bundle.
REQ-012 SHALL have port out_valid_o, output, OUT_WIDTH bits: output slot k holds a uop.
REQ-013 SHALL have port out_uop_o, output, OUT_WIDTH*UOP_W bits: slot 0 holds the oldest uop.
REQ-014 SHALL have port out_ready_i, input, 1 bit: rename consumes all valid output slots this cycle.
REQ-015 SHALL have port flush_i, input, 1 bit: pipeline flush, from recovery or exception.
REQ-016 SHALL have port count_o, output, clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-017 SHALL be a circular buffer with head (oldest), tail and count registers; head and tail wrap modulo DEPTH.
REQ-018 SHALL drive in_ready_o = (DEPTH - count >= 2*FETCH_WIDTH), computed from the registered count only; a same-cycle pop SHALL NOT raise it.
REQ-019 SHALL push when in_valid_i && in_ready_o && !flush_i.
REQ-020 SHALL treat a slot as pushed only when uop_valid_i is set and lane_active_i for its lane is set; slots of inactive lanes SHALL be dropped.
REQ-021 SHALL compact pushed uops with no gaps in ascending slot order: lane order, part0 before part1.
REQ-022 SHALL write pushed uops starting at tail and advance tail by the number pushed (0..2*FETCH_WIDTH); a bundle with zero pushed uops SHALL leave state unchanged.
REQ-023 SHALL drive out_valid_o[k] = (count > k) and out_uop_o slot k = entry (head+k) mod DEPTH, combinationally from registered state.
REQ-024 SHALL pop on out_ready_i && !flush_i, removing min(count, OUT_WIDTH) entries and advancing head by that amount; out_ready_i with count = 0 SHALL be a no-op.
REQ-025 SHALL update count to count + pushed - popped when push and pop occur in the same cycle.
REQ-026 SHALL make a pushed uop first visible on out_valid_o the cycle after the push (1-cycle latency).
REQ-027 SHALL, on flush_i, set head = tail = count = 0 at the next edge, overriding any push or pop in that cycle.
REQ-028 SHALL NOT overflow or underflow count under any input combination; count SHALL stay within 0..DEPTH.
REQ-029 SHALL drive count_o equal to the count register.

Reset
REQ-030 SHALL, on reset low, asynchronously set head = tail = count = 0, so out_valid_o = 0, count_o = 0 and in_ready_o = 1.
REQ-031 SHALL NOT reset the payload storage; stale payload SHALL never appear under a set out_valid_o bit.
REQ-032 SHALL abort any in-flight push or pop on reset assertion mid-operation; the first push after deassertion SHALL land at entry 0.

Verification
REQ-033 Compaction: FW=4, lanes all active, uop_valid_i=8'b0100_0101, count 0 -> next cycle count_o=3, out_valid_o=4'b0111, slots 0..2 = slot0, slot2, slot6 payloads.
REQ-034 Lane gating: lane_active_i=4'b0101, uop_valid_i=8'hFF -> exactly 4 uops pushed: lane0 part0, lane0 part1, lane2 part0, lane2 part1.
REQ-035 Full and wrap: fill to count 10 with DEPTH=16 -> in_ready_o=0; pop 4 -> count 6, in_ready_o=1; the next 8-uop push wraps tail past entry 15 and all 14 uops drain in order.
REQ-036 Simultaneous push and pop: count 9 with in_ready_o=0, in_valid_i=1, out_ready_i=1 -> only the pop takes effect, count 5; the next cycle accepts the bundle.
REQ-037 Flush priority: count 6 with flush_i=1, in_valid_i=1 and out_ready_i=1 in the same cycle -> next cycle count_o=0, out_valid_o=0, in_ready_o=1.
REQ-038 Reset mid-operation: reset pulsed low between edges while count=7 -> outputs clear immediately; after release a single-uop push appears at slot 0 one cycle later.
